// File: rtl/mux_pkg.sv
// Shared defaults for the 2:1 word mux with registered capture path.
package mux_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 16;

endpackage : mux_pkg

// File: rtl/mux32_bit2_to1_if.sv
// Operand/result bundle for mux32_bit2_to1; master drives operands, slave returns results.
interface mux32_bit2_to1_if
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [WIDTH-1:0] inA;
  logic [WIDTH-1:0] inB;
  logic             sel;
  logic             en;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             out_q_valid;
  logic             in_equal;
  logic [CNT_W-1:0] sel_toggles;

  modport master (
    output inA, inB, sel, en,
    input  out, out_q, out_q_valid, in_equal, sel_toggles
  );

  modport slave (
    input  inA, inB, sel, en,
    output out, out_q, out_q_valid, in_equal, sel_toggles
  );

endinterface : mux32_bit2_to1_if

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous active-high reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/mux32_bit2_to1.sv
// 2:1 word mux with equality flag, plus an enabled capture register that
// remembers the last select and counts select changes between captures.
module mux32_bit2_to1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic              Clk,
  input logic              Rst,
  mux32_bit2_to1_if.slave  bus
);

  logic [WIDTH-1:0] mux_out;
  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;
  logic             valid_d;
  logic             valid_q;
  logic             sel_last_d;
  logic             sel_last_q;
  logic             toggle_inc;
  logic [CNT_W-1:0] toggle_count;

  // Plain ternary so an unknown select resolves with simulator semantics.
  assign mux_out = bus.sel ? bus.inB : bus.inA;

  // A toggle only counts once a previous capture exists to compare against.
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    sel_last_d = sel_last_q;
    toggle_inc = 1'b0;
    if (bus.en) begin
      data_d     = mux_out;
      valid_d    = 1'b1;
      sel_last_d = bus.sel;
      toggle_inc = valid_q && (bus.sel != sel_last_q);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      data_q     <= '0;
      valid_q    <= 1'b0;
      sel_last_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      sel_last_q <= sel_last_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_toggle_cnt (
    .Clk   (Clk),
    .Rst   (Rst),
    .inc   (toggle_inc),
    .count (toggle_count)
  );

  assign bus.out         = mux_out;
  assign bus.in_equal    = (bus.inA == bus.inB);
  assign bus.out_q       = data_q;
  assign bus.out_q_valid = valid_q;
  assign bus.sel_toggles = toggle_count;

endmodule : mux32_bit2_to1

// File: tb/tb_mux32_bit2_to1.sv
// Directed bench: combinational vector table with the clock parked, then
// hand-written capture/toggle/saturation/reset sequences on two counter widths.
module tb_mux32_bit2_to1;

  typedef struct {
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        sel;
    logic [31:0] exp_out;
    logic        exp_equal;
  } comb_vec_t;

  localparam logic [31:0] SEQ_A = 32'h1111_1111;
  localparam logic [31:0] SEQ_B = 32'h2222_2222;

  logic clk;
  logic rst;
  logic clk_run;
  int   checks;
  int   errors;

  mux32_bit2_to1_if #(.WIDTH(32), .CNT_W(16)) bus ();
  mux32_bit2_to1_if #(.WIDTH(32), .CNT_W(2))  bus_s ();

  mux32_bit2_to1 #(.WIDTH(32), .CNT_W(16)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  mux32_bit2_to1 #(.WIDTH(32), .CNT_W(2)) dut_s (
    .Clk (clk),
    .Rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s, input logic e);
    bus.inA   = a;
    bus.inB   = b;
    bus.sel   = s;
    bus.en    = e;
    bus_s.inA = a;
    bus_s.inB = b;
    bus_s.sel = s;
    bus_s.en  = e;
  endtask

  // One clock edge with hand-computed expectations for both counter widths.
  task automatic step(input logic r, input logic e, input logic s, input logic [31:0] exp_q,
                      input logic exp_v, input int exp_tog, input int exp_tog_s);
    rst = r;
    applyStimulus(SEQ_A, SEQ_B, s, e);
    @(posedge clk);
    #1;
    checkOutput("out_q", bus.out_q, exp_q);
    checkOutput("out_q_valid", 32'(bus.out_q_valid), 32'(exp_v));
    checkOutput("sel_toggles", 32'(bus.sel_toggles), exp_tog);
    checkOutput("sel_toggles_cnt2", 32'(bus_s.sel_toggles), exp_tog_s);
    checkOutput("out_during_seq", bus.out, s ? SEQ_B : SEQ_A);
  endtask

  comb_vec_t vecs[9];

  initial begin
    checks  = 0;
    errors  = 0;
    clk_run = 1'b0;
    rst     = 1'b0;

    vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0001, 1'b0};
    vecs[1] = '{32'h0000_0001, 32'h0000_0002, 1'b1, 32'h0000_0002, 1'b0};
    vecs[2] = '{32'hF000_0001, 32'hF000_0002, 1'b0, 32'hF000_0001, 1'b0};
    vecs[3] = '{32'hF000_0001, 32'hF000_0002, 1'b1, 32'hF000_0002, 1'b0};
    vecs[4] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b1};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b0};
    vecs[7] = '{32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0};
    vecs[8] = '{32'h1234_5678, 32'h1234_5679, 1'b0, 32'h1234_5678, 1'b0};

    // Clock parked and never reset: combinational outputs must still be right.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].in_a, vecs[i].in_b, vecs[i].sel, 1'b0);
      #20;
      checkOutput($sformatf("out_vec%0d", i), bus.out, vecs[i].exp_out);
      checkOutput($sformatf("in_equal_vec%0d", i), 32'(bus.in_equal), 32'(vecs[i].exp_equal));
      checkOutput($sformatf("out_cnt2_vec%0d", i), bus_s.out, vecs[i].exp_out);
    end

    clk_run = 1'b1;

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, SEQ_A, 1'b1, 0, 0);
    step(1'b0, 1'b1, 1'b1, SEQ_B, 1'b1, 1, 1);
    step(1'b0, 1'b1, 1'b0, SEQ_A, 1'b1, 2, 2);
    step(1'b0, 1'b1, 1'b1, SEQ_B, 1'b1, 3, 3);
    // en low: everything holds even though sel moves.
    step(1'b0, 1'b0, 1'b0, SEQ_B, 1'b1, 3, 3);
    // Narrow counter pinned at all-ones while the wide one keeps counting.
    step(1'b0, 1'b1, 1'b0, SEQ_A, 1'b1, 4, 3);
    step(1'b0, 1'b1, 1'b1, SEQ_B, 1'b1, 5, 3);
    step(1'b0, 1'b1, 1'b0, SEQ_A, 1'b1, 6, 3);
    // Reset wins over a simultaneous capture.
    step(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 0, 0);
    // First capture after reset differs from the cleared sel_last but must not count.
    step(1'b0, 1'b1, 1'b1, SEQ_B, 1'b1, 0, 0);
    step(1'b0, 1'b1, 1'b1, SEQ_B, 1'b1, 0, 0);
    step(1'b0, 1'b1, 1'b0, SEQ_A, 1'b1, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux32_bit2_to1
